ldtu_lane_serializer: RTL and testbench

Next-generation output serializer for the LiTE-DTU datapath. It converts NLANES parallel WORD_W-bit words into NLANES one-bit serial streams. It issues a handshake to the datapath ahead of each word boundary, and inserts an idle/training pattern when data is absent or training is requested. It adds per-lane enables, bit order selection and underflow monitoring, and sits between the DTU encoder outputs and the pad drivers.

---
 rtl/ldtu_ser_pkg.sv | 26 ++
 rtl/ldtu_ser_lane.sv | 40 ++++
 rtl/ldtu_lane_serializer.sv | 106 ++++++++++
 tb/tb_ldtu_lane_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ldtu_ser_pkg.sv
// Shared constants, lane source encoding and helpers for the LiTE-DTU lane serializer.
package ldtu_ser_pkg;

  localparam int NLANES_DEF  = 4;
  localparam int WORD_W_DEF  = 32;
  localparam int HS_LEAD_DEF = 2;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_IDLE = 2'd1,
    SRC_DATA = 2'd2
  } src_e;

  function automatic int cnt_w(input int word_w);
    return $clog2(word_w);
  endfunction

  // Priority: disabled lane, then forced idle (first word / training), then data, else idle (underflow).
  function automatic src_e src_sel(input logic lane_en, input logic force_idle, input logic valid);
    if (!lane_en)   return SRC_ZERO;
    if (force_idle) return SRC_IDLE;
    if (valid)      return SRC_DATA;
    return SRC_IDLE;
  endfunction

endpackage

// File: rtl/ldtu_ser_lane.sv
// One serial lane: word shift register with source mux and selectable bit order.
module ldtu_ser_lane
  import ldtu_ser_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int LSB_FIRST = 0
) (
  input  logic              clock,
  input  logic              rst_b,
  input  logic              i_clr,
  input  logic              i_load,
  input  src_e              i_src,
  input  logic [WORD_W-1:0] i_data,
  input  logic [WORD_W-1:0] i_idle,
  output logic              o_ser
);

  logic [WORD_W-1:0] r_sh;
  logic [WORD_W-1:0] w_ld;

  always_comb begin
    w_ld = '0;
    case (i_src)
      SRC_DATA: w_ld = i_data;
      SRC_IDLE: w_ld = i_idle;
      default:  w_ld = '0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b)              r_sh <= '0;
    else if (i_clr)          r_sh <= '0;
    else if (i_load)         r_sh <= w_ld;
    else if (LSB_FIRST != 0) r_sh <= r_sh >> 1;
    else                     r_sh <= r_sh << 1;
  end

  assign o_ser = (LSB_FIRST != 0) ? r_sh[0] : r_sh[WORD_W-1];

endmodule

// File: rtl/ldtu_lane_serializer.sv
// Multi-lane word serializer: bit counter, early handshake, first-word/training idle insertion
// and underflow monitoring around an array of ldtu_ser_lane shifters.
module ldtu_lane_serializer
  import ldtu_ser_pkg::*;
#(
  parameter int NLANES    = NLANES_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int HS_LEAD   = HS_LEAD_DEF,
  parameter int LSB_FIRST = 0,
  parameter int UFL_CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     rst_b,
  input  logic                     enable,
  input  logic                     training,
  input  logic [NLANES-1:0]        lane_en,
  input  logic [NLANES*WORD_W-1:0] data_in,
  input  logic                     data_valid,
  input  logic [WORD_W-1:0]        idle_pattern,
  input  logic                     underflow_clr,
  output logic                     handshake,
  output logic                     word_strobe,
  output logic [NLANES-1:0]        ser_out,
  output logic                     underflow,
  output logic [UFL_CNT_W-1:0]     underflow_cnt
);

  localparam int               CNT_W   = cnt_w(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] HS_CNT  = CNT_W'(WORD_W - 1 - HS_LEAD);

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_first;
  logic                 r_hs;
  logic                 r_ws;
  logic                 r_ufl;
  logic [UFL_CNT_W-1:0] r_ufl_cnt;

  logic             w_load;
  logic             w_force_idle;
  logic             w_ufl_evt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // While disabled the counter parks at WORD_W-1, so the first enabled edge is a load edge.
  assign w_load       = enable && (r_cnt == CNT_MAX);
  assign w_cnt_nxt    = w_load ? '0 : r_cnt + CNT_W'(1);
  assign w_force_idle = r_first | training;
  assign w_ufl_evt    = w_load && (|lane_en) && !w_force_idle && !data_valid;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt     <= CNT_MAX;
      r_first   <= 1'b1;
      r_hs      <= 1'b0;
      r_ws      <= 1'b0;
      r_ufl     <= 1'b0;
      r_ufl_cnt <= '0;
    end else begin
      if (!enable) begin
        r_cnt   <= CNT_MAX;
        r_first <= 1'b1;
        r_hs    <= 1'b0;
        r_ws    <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_hs  <= (w_cnt_nxt == HS_CNT);
        r_ws  <= w_load;
        if (w_load) r_first <= 1'b0;
      end
      // A new underflow beats a simultaneous clear: it restarts the count at one.
      if (w_ufl_evt) begin
        r_ufl <= 1'b1;
        if (underflow_clr)    r_ufl_cnt <= UFL_CNT_W'(1);
        else if (!(&r_ufl_cnt)) r_ufl_cnt <= r_ufl_cnt + UFL_CNT_W'(1);
      end else if (underflow_clr) begin
        r_ufl     <= 1'b0;
        r_ufl_cnt <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    src_e w_src;
    assign w_src = src_sel(lane_en[gi], w_force_idle, data_valid);

    ldtu_ser_lane #(
      .WORD_W    (WORD_W),
      .LSB_FIRST (LSB_FIRST)
    ) u_lane (
      .clock  (clock),
      .rst_b  (rst_b),
      .i_clr  (~enable),
      .i_load (w_load),
      .i_src  (w_src),
      .i_data (data_in[gi*WORD_W +: WORD_W]),
      .i_idle (idle_pattern),
      .o_ser  (ser_out[gi])
    );
  end

  assign handshake     = r_hs;
  assign word_strobe   = r_ws;
  assign underflow     = r_ufl;
  assign underflow_cnt = r_ufl_cnt;

endmodule

// File: tb/tb_ldtu_lane_serializer.sv
// Directed bench for ldtu_lane_serializer: table of per-boundary vectors plus hand sequences
// for mid-word lane_en change, enable abort, counter saturation/clear and reset mid-word.
module tb_ldtu_lane_serializer;

  localparam int NL = 4;
  localparam int WW = 32;

  localparam logic [NL-1:0][WW-1:0] IDLE4 = {4{32'hBC50_BC50}};
  localparam logic [NL-1:0][WW-1:0] DA = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
  localparam logic [NL-1:0][WW-1:0] DB = {32'h0F0F_1233, 32'h0F0F_1232, 32'h0F0F_1231, 32'h0F0F_1230};
  localparam logic [NL-1:0][WW-1:0] DC = {32'hC0DE_F003, 32'hC0DE_F002, 32'hC0DE_F001, 32'hC0DE_F000};
  localparam logic [NL-1:0][WW-1:0] ZZ = '0;

  logic                  clock = 1'b0;
  logic                  rst_b = 1'b0;
  logic                  enable = 1'b0;
  logic                  training = 1'b0;
  logic                  data_valid = 1'b0;
  logic                  underflow_clr = 1'b0;
  logic [NL-1:0]         lane_en = '1;
  logic [NL-1:0][WW-1:0] din = '0;
  logic [NL-1:0][WW-1:0] dl = '0;
  logic [WW-1:0]         idle = 32'hBC50_BC50;

  logic          handshake, word_strobe, underflow;
  logic [NL-1:0] ser_out;
  logic [7:0]    underflow_cnt;
  logic          l_hs, l_ws, l_uf;
  logic [NL-1:0] l_ser;
  logic [7:0]    l_ucnt;

  always #5 clock = ~clock;

  ldtu_lane_serializer #(.NLANES(NL), .WORD_W(WW), .HS_LEAD(2), .LSB_FIRST(0), .UFL_CNT_W(8)) u_dut (
    .clock(clock), .rst_b(rst_b), .enable(enable), .training(training), .lane_en(lane_en),
    .data_in(din), .data_valid(data_valid), .idle_pattern(idle), .underflow_clr(underflow_clr),
    .handshake(handshake), .word_strobe(word_strobe), .ser_out(ser_out),
    .underflow(underflow), .underflow_cnt(underflow_cnt));

  ldtu_lane_serializer #(.NLANES(NL), .WORD_W(WW), .HS_LEAD(2), .LSB_FIRST(1), .UFL_CNT_W(8)) u_lsb (
    .clock(clock), .rst_b(rst_b), .enable(enable), .training(training), .lane_en(lane_en),
    .data_in(dl), .data_valid(data_valid), .idle_pattern(idle), .underflow_clr(underflow_clr),
    .handshake(l_hs), .word_strobe(l_ws), .ser_out(l_ser),
    .underflow(l_uf), .underflow_cnt(l_ucnt));

  typedef struct {
    logic [NL-1:0]         en;
    logic                  tr;
    logic                  dv;
    logic [NL-1:0][WW-1:0] din;
    logic [NL-1:0][WW-1:0] exp;
    logic [7:0]            ucnt;
    logic                  uf;
  } vec_t;

  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;
  int   tcnt = WW - 1;

  logic [NL-1:0][WW-1:0] cw, cwl;
  int hs_n, hs_pos, ws_n, ws_pos, lhs_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected bit-counter value is tracked by the bench itself.
  task automatic step();
    logic en;
    en = enable & rst_b;
    @(posedge clock);
    #1;
    tcnt = en ? ((tcnt == WW - 1) ? 0 : tcnt + 1) : WW - 1;
  endtask

  task automatic run_to(input int n);
    int k;
    k = 0;
    while (tcnt != n && k < 64) begin
      step();
      k++;
    end
    chk("run_to", 64'(tcnt), 64'(n));
  endtask

  // Collect one full word from every lane; starts with tcnt==WW-1 so the next edge is a load edge.
  task automatic capture(input int chg_at, input logic [NL-1:0] chg_en);
    cw = '0; cwl = '0;
    hs_n = 0; hs_pos = -1; ws_n = 0; ws_pos = -1; lhs_n = 0;
    for (int b = 0; b < WW; b++) begin
      step();
      for (int l = 0; l < NL; l++) begin
        cw[l]  = {cw[l][WW-2:0], ser_out[l]};
        cwl[l] = {l_ser[l], cwl[l][WW-1:1]};
      end
      if (handshake) begin hs_n++; hs_pos = tcnt; end
      if (word_strobe) begin ws_n++; ws_pos = tcnt; end
      if (l_hs) lhs_n++;
      if (l_ws) lhs_n++;
      if (b == chg_at) lane_en = chg_en;
    end
  endtask

  task automatic chk_word(input string tag, input logic [NL-1:0][WW-1:0] exp);
    for (int l = 0; l < NL; l++) chk($sformatf("%s_lane%0d", tag, l), 64'(cw[l]), 64'(exp[l]));
    chk({tag, "_hs"}, {32'(hs_n), 32'(hs_pos)}, {32'd1, 32'd29});
    chk({tag, "_ws"}, {32'(ws_n), 32'(ws_pos)}, {32'd1, 32'd0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 1'b0, 1'b1, DB, DB, 8'd0, 1'b0};
    tbl[1] = '{4'b1111, 1'b1, 1'b0, DB, IDLE4, 8'd0, 1'b0};
    tbl[2] = '{4'b0110, 1'b0, 1'b1, DC, {32'h0, 32'hC0DE_F002, 32'hC0DE_F001, 32'h0}, 8'd0, 1'b0};
    tbl[3] = '{4'b1111, 1'b0, 1'b0, DC, IDLE4, 8'd1, 1'b1};
    tbl[4] = '{4'b1111, 1'b0, 1'b0, DC, IDLE4, 8'd2, 1'b1};
    tbl[5] = '{4'b1001, 1'b0, 1'b0, DC, {32'hBC50_BC50, 32'h0, 32'h0, 32'hBC50_BC50}, 8'd3, 1'b1};
    tbl[6] = '{4'b0000, 1'b0, 1'b0, DC, ZZ, 8'd3, 1'b1};
    tbl[7] = '{4'b1111, 1'b1, 1'b0, DC, IDLE4, 8'd3, 1'b1};
    tbl[8] = '{4'b1111, 1'b0, 1'b1, DA, DA, 8'd3, 1'b1};

    repeat (3) step();
    chk("rst_ser", 64'(ser_out), 64'd0);
    chk("rst_hs", 64'(handshake), 64'd0);
    chk("rst_ws", 64'(word_strobe), 64'd0);
    chk("rst_uf", 64'(underflow), 64'd0);
    chk("rst_ucnt", 64'(underflow_cnt), 64'd0);

    rst_b = 1'b1;
    repeat (2) step();
    chk("dis_ser", 64'(ser_out), 64'd0);

    lane_en = 4'b1111; din = DA; data_valid = 1'b1;
    for (int l = 0; l < NL; l++) dl[l] = 32'h0000_0001;
    enable = 1'b1;
    capture(-1, '0);
    chk_word("first", IDLE4);
    for (int l = 0; l < NL; l++) chk($sformatf("lsb_first_lane%0d", l), 64'(cwl[l]), 64'hBC50_BC50);
    chk("lsb_hsws", 64'(lhs_n), 64'd2);
    capture(-1, '0);
    chk_word("second", DA);
    for (int l = 0; l < NL; l++) chk($sformatf("lsb_one_lane%0d", l), 64'(cwl[l]), 64'h1);
    chk("second_ufl", {55'd0, underflow, underflow_cnt}, 64'd0);
    chk("lsb_ufl", {55'd0, l_uf, l_ucnt}, 64'd0);

    for (int r = 0; r < 9; r++) begin
      lane_en = tbl[r].en; training = tbl[r].tr; data_valid = tbl[r].dv; din = tbl[r].din;
      capture(-1, '0);
      chk_word($sformatf("row%0d", r), tbl[r].exp);
      chk($sformatf("row%0d_ucnt", r), 64'(underflow_cnt), 64'(tbl[r].ucnt));
      chk($sformatf("row%0d_uf", r), 64'(underflow), 64'(tbl[r].uf));
    end

    // lane_en drops lanes 1 and 3 mid-word: current word completes, next word is zero there.
    training = 1'b0; lane_en = 4'b1111; data_valid = 1'b1; din = DA;
    capture(10, 4'b0101);
    chk_word("lechg_cur", DA);
    capture(-1, '0);
    chk_word("lechg_next", {32'h0, 32'hA5A5_0002, 32'h0, 32'hA5A5_0000});

    // enable falling mid-word aborts; re-enable starts with idle_pattern.
    lane_en = 4'b1111;
    run_to(12);
    enable = 1'b0;
    step();
    chk("abort_ser", 64'(ser_out), 64'd0);
    chk("abort_hs", 64'(handshake), 64'd0);
    chk("abort_ws", 64'(word_strobe), 64'd0);
    enable = 1'b1;
    capture(-1, '0);
    chk_word("reen", IDLE4);
    chk("reen_ucnt", 64'(underflow_cnt), 64'd3);

    data_valid = 1'b0;
    repeat (300) repeat (WW) step();
    chk("sat_ucnt", 64'(underflow_cnt), 64'd255);
    chk("sat_uf", 64'(underflow), 64'd1);

    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("clr_evt_ucnt", 64'(underflow_cnt), 64'd1);
    chk("clr_evt_uf", 64'(underflow), 64'd1);
    repeat (WW - 1) step();

    training = 1'b1;
    capture(-1, '0);
    chk_word("train", IDLE4);
    chk("train_ucnt", 64'(underflow_cnt), 64'd1);

    run_to(17);
    rst_b = 1'b0;
    #1;
    tcnt = WW - 1;
    chk("mrst_ser", 64'(ser_out), 64'd0);
    chk("mrst_hs", 64'(handshake), 64'd0);
    chk("mrst_ucnt", 64'(underflow_cnt), 64'd0);
    chk("mrst_uf", 64'(underflow), 64'd0);
    step();
    rst_b = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
